// File: rtl/wb_arbiter.sv
// wb_arbiter
//
// Writeback arbiter and register scoreboard feeding the single register file
// write port. Single-cycle ALU results and LSU load results share the port.
// Every LSU beat is buffered in a small FIFO. A starvation counter guarantees
// that the FIFO head is serviced even while the ALU presents results every cycle.
//
// Optional feature: define WB_PERF_EN to add the stall_cnt performance counter.
//
// Parameters
//   LSU_DEPTH   LSU result FIFO entries (power of two, >= 2)
//   STARVE_MAX  cycles a non-empty FIFO may lose arbitration before it wins (>= 1)
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   alu_valid/ready       ALU result handshake; alu_regno/alu_data carry the result
//   lsu_valid/ready       LSU result handshake; lsu_regno/lsu_data carry the load value
//   rsv_valid/rsv_regno   issue-side reservation of a destination register
//   busy                  per-register pending-write bits (bit 0 always 0)
//   regdata_w/regno_w     registered register file write data/index
//   write                 registered register file write enable
//   stall_cnt             (WB_PERF_EN only) count of stalled valid cycles

module wb_arbiter #(
    parameter int unsigned LSU_DEPTH  = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [5:0]  alu_regno,
    input  logic [31:0] alu_data,

    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [5:0]  lsu_regno,
    input  logic [31:0] lsu_data,

    input  logic        rsv_valid,
    input  logic [5:0]  rsv_regno,

    output logic [31:0] busy,
`ifdef WB_PERF_EN
    output logic [31:0] stall_cnt,
`endif
    output logic [31:0] regdata_w,
    output logic [5:0]  regno_w,
    output logic        write
);

    localparam int unsigned PtrW  = $clog2(LSU_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned WaitW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [CntW-1:0]  DepthCnt  = CntW'(LSU_DEPTH);
    localparam logic [WaitW-1:0] StarveCnt = WaitW'(STARVE_MAX);

    // Register index bit 5 is architecturally ignored on every input.
    logic unused_regno_msb;
    assign unused_regno_msb = ^{alu_regno[5], lsu_regno[5], rsv_regno[5]};

    // ------------------------------------------------------------------
    // LSU FIFO state
    // ------------------------------------------------------------------
    logic [31:0]      fifo_data  [LSU_DEPTH];
    logic [4:0]       fifo_regno [LSU_DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WaitW-1:0] wait_q, wait_d;

    logic fifo_full;
    logic fifo_nonempty;
    logic starve;
    logic push;
    logic pop;
    logic alu_take;

    assign fifo_full     = (count_q == DepthCnt);
    assign fifo_nonempty = (count_q != '0);

    // The head has lost arbitration STARVE_MAX times in a row; it wins now.
    assign starve = fifo_nonempty && (wait_q == StarveCnt);

    // Both readies come from registered state only (plus reset gating).
    assign alu_ready = rst_n && !starve;
    assign lsu_ready = rst_n && !fifo_full;

    assign push     = lsu_valid && lsu_ready;
    assign pop      = rst_n && (starve || (!alu_valid && fifo_nonempty));
    assign alu_take = alu_valid && alu_ready;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    logic        win;
    logic [4:0]  win_regno;
    logic [31:0] win_data;

    always_comb begin
        win       = 1'b0;
        win_regno = '0;
        win_data  = '0;
        if (pop) begin
            win       = 1'b1;
            win_regno = fifo_regno[rd_ptr_q];
            win_data  = fifo_data[rd_ptr_q];
        end else if (alu_take) begin
            win       = 1'b1;
            win_regno = alu_regno[4:0];
            win_data  = alu_data;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointer / count / starvation counter next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wait_d   = wait_q;

        // Pointers wrap naturally because LSU_DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Age of the current head in lost arbitration rounds.
        if (pop || !fifo_nonempty) begin
            wait_d = '0;
        end else if (wait_q != StarveCnt) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
        end
    end

    // Storage needs no reset; entries are only read when count_q says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q]  <= lsu_data;
            fifo_regno[wr_ptr_q] <= lsu_regno[4:0];
        end
    end

    // ------------------------------------------------------------------
    // Register file write port
    // ------------------------------------------------------------------
    logic        write_q;
    logic [4:0]  regno_q;
    logic [31:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            regno_q <= '0;
            data_q  <= '0;
        end else if (win) begin
            // A winner targeting x0 completes its handshake but never writes.
            write_q <= (win_regno != 5'd0);
            regno_q <= win_regno;
            data_q  <= win_data;
        end else begin
            write_q <= 1'b0;
        end
    end

    assign write     = write_q;
    assign regno_w   = {1'b0, regno_q};
    assign regdata_w = data_q;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (write_q) begin
            busy_d[regno_q] = 1'b0;
        end
        // Applied after the clear: a new reservation outranks a retiring write.
        if (rsv_valid && (rsv_regno[4:0] != 5'd0)) begin
            busy_d[rsv_regno[4:0]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

`ifdef WB_PERF_EN
    // ------------------------------------------------------------------
    // Stall performance counter
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q;
    logic [1:0]  stall_inc;

    assign stall_inc = {1'b0, alu_valid && !alu_ready} + {1'b0, lsu_valid && !lsu_ready};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(stall_inc);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
//
// Self-checking bench for wb_arbiter. A queue-based reference model tracks the
// LSU buffer, the head's lost-arbitration age, the scoreboard and the expected
// write port, and is compared against the DUT on every falling edge. Directed
// sequences with hand-derived literal expectations pin the model, followed by
// a randomized phase with occasional resets.

module tb_wb_arbiter;

    localparam int unsigned Depth  = 4;
    localparam int unsigned Starve = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [5:0]  alu_regno;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [5:0]  lsu_regno;
    logic [31:0] lsu_data;
    logic        rsv_valid;
    logic [5:0]  rsv_regno;
    logic [31:0] busy;
    logic [31:0] regdata_w;
    logic [5:0]  regno_w;
    logic        write;
`ifdef WB_PERF_EN
    logic [31:0] stall_cnt;
`endif

    wb_arbiter #(
        .LSU_DEPTH (Depth),
        .STARVE_MAX(Starve)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_regno(alu_regno),
        .alu_data (alu_data),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_regno(lsu_regno),
        .lsu_data (lsu_data),
        .rsv_valid(rsv_valid),
        .rsv_regno(rsv_regno),
        .busy     (busy),
`ifdef WB_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .regdata_w(regdata_w),
        .regno_w  (regno_w),
        .write    (write)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: state as seen after the most recent rising edge
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          m_age = 0;
    bit          m_write = 1'b0;
    logic [4:0]  m_regno = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_busy = '0;
    logic [31:0] m_stall = '0;

    always @(negedge clk) begin
        bit          e_starve, e_alu_rdy, e_lsu_rdy, won;
        int          pre_size;
        ent_t        e;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] nb;

        e_starve  = (mq.size() != 0) && (m_age == Starve);
        e_alu_rdy = rst_n && !e_starve;
        e_lsu_rdy = rst_n && (mq.size() < Depth);

        if (chk_en) begin
            chk("alu_ready", 32'(alu_ready), 32'(e_alu_rdy));
            chk("lsu_ready", 32'(lsu_ready), 32'(e_lsu_rdy));
            chk("write", 32'(write), 32'(m_write));
            chk("busy", busy, m_busy);
            if (m_write) begin
                chk("regno_w", 32'(regno_w), 32'(m_regno));
                chk("regdata_w", regdata_w, m_data);
            end
`ifdef WB_PERF_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
        end

        if (!rst_n) begin
            mq.delete();
            m_age   = 0;
            m_write = 1'b0;
            m_regno = '0;
            m_data  = '0;
            m_busy  = '0;
            m_stall = '0;
        end else begin
            m_stall = m_stall + 32'(alu_valid && !e_alu_rdy) + 32'(lsu_valid && !e_lsu_rdy);
            pre_size = mq.size();
            won = 1'b0;
            wr  = '0;
            wd  = '0;
            if (e_starve || (!alu_valid && pre_size != 0)) begin
                e   = mq.pop_front();
                won = 1'b1;
                wr  = e.r;
                wd  = e.d;
            end else if (alu_valid) begin
                won = 1'b1;
                wr  = alu_regno[4:0];
                wd  = alu_data;
            end
            if (lsu_valid && e_lsu_rdy) begin
                mq.push_back('{r: lsu_regno[4:0], d: lsu_data});
            end
            // Head age: how many rounds the current head has lost in a row.
            if (pre_size == 0 || (won && pre_size > mq.size() - int'(lsu_valid && e_lsu_rdy))) begin
                m_age = 0;
            end else if (m_age < Starve) begin
                m_age++;
            end
            nb = m_busy;
            if (m_write) nb[m_regno] = 1'b0;
            if (rsv_valid && rsv_regno[4:0] != 0) nb[rsv_regno[4:0]] = 1'b1;
            m_busy = nb;
            if (won) begin
                m_write = (wr != 0);
                m_regno = wr;
                m_data  = wd;
            end else begin
                m_write = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus and directed checks
    // ------------------------------------------------------------------
    logic [31:0] got[$];
    int          n_pushed;
    bit          saw_full;
    bit          hs;
    int          zeros;

    initial begin
        rst_n     = 1'b0;
        alu_valid = 1'b1;
        alu_regno = 6'd4;
        alu_data  = 32'h1111_1111;
        lsu_valid = 1'b1;
        lsu_regno = 6'd6;
        lsu_data  = 32'h2222_2222;
        rsv_valid = 1'b1;
        rsv_regno = 6'd8;

        // Reset held two cycles with every valid asserted.
        tick();
        tick();
        @(negedge clk);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        chk_en = 1'b1;

        tick();
        rst_n     = 1'b1;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        rsv_valid = 1'b0;
        @(negedge clk);
        chk("rel_alu_ready", 32'(alu_ready), 32'd1);
        chk("rel_lsu_ready", 32'(lsu_ready), 32'd1);

        // ALU single write to x5.
        tick();
        rsv_valid = 1'b1;
        rsv_regno = 6'd5;
        tick();
        rsv_valid = 1'b0;
        alu_valid = 1'b1;
        alu_regno = 6'd5;
        alu_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("alu_busy_set", 32'(busy[5]), 32'd1);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_write", 32'(write), 32'd1);
        chk("alu_regno_w", 32'(regno_w), 32'd5);
        chk("alu_regdata_w", regdata_w, 32'hDEAD_BEEF);
        chk("alu_busy_hold", 32'(busy[5]), 32'd1);
        tick();
        @(negedge clk);
        chk("alu_busy_clr", 32'(busy[5]), 32'd0);

        // LSU starvation with the ALU saturated.
        tick();
        alu_valid = 1'b1;
        alu_regno = 6'd3;
        alu_data  = 32'h0000_0033;
        lsu_valid = 1'b1;
        lsu_regno = 6'd7;
        lsu_data  = 32'h0000_1234;
        tick();
        lsu_valid = 1'b0;
        zeros = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!alu_ready) zeros++;
            if (k == 3) chk("starve_alu_ready", 32'(alu_ready), 32'd0);
            if (k == 4) begin
                chk("starve_regno_w", 32'(regno_w), 32'd7);
                chk("starve_regdata_w", regdata_w, 32'h0000_1234);
            end
            if (k == 5) begin
                chk("resume_write", 32'(write), 32'd1);
                chk("resume_regno_w", 32'(regno_w), 32'd3);
            end
        end
        chk("starve_one_cycle", 32'(zeros), 32'd1);

        // FIFO fill: five LSU beats back-to-back against a saturated ALU.
        tick();
        n_pushed = 0;
        saw_full = 1'b0;
        got.delete();
        for (int c = 0; c < 60; c++) begin
            lsu_valid = (n_pushed < 5);
            lsu_regno = 6'(10 + n_pushed);
            lsu_data  = 32'hA000 + 32'(n_pushed);
            @(negedge clk);
            if (write && regno_w >= 6'd10 && regno_w <= 6'd14) got.push_back(regdata_w);
            if (!lsu_ready) saw_full = 1'b1;
            hs = lsu_valid && lsu_ready;
            tick();
            if (hs) n_pushed++;
        end
        chk("full_seen", 32'(saw_full), 32'd1);
        chk("full_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < got.size() && i < 5; i++) begin
            chk("full_order", got[i], 32'hA000 + 32'(i));
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;

        // Write to x0 (bit 5 set, ignored): handshake completes, no write.
        tick();
        alu_valid = 1'b1;
        alu_regno = 6'h20;
        alu_data  = 32'h0000_0BAD;
        @(negedge clk);
        chk("x0_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("x0_write", 32'(write), 32'd0);

        // Reserve x9 on the edge where the previous x9 write retires.
        tick();
        rsv_valid = 1'b1;
        rsv_regno = 6'd9;
        tick();
        rsv_valid = 1'b0;
        alu_valid = 1'b1;
        alu_regno = 6'd9;
        alu_data  = 32'h9999_0009;
        tick();
        alu_valid = 1'b0;
        rsv_valid = 1'b1;
        rsv_regno = 6'd9;
        @(negedge clk);
        chk("coll_write", 32'(write), 32'd1);
        chk("coll_regno_w", 32'(regno_w), 32'd9);
        tick();
        rsv_valid = 1'b0;
        @(negedge clk);
        chk("coll_busy9", 32'(busy[9]), 32'd1);

        // From reset: ALU and LSU both streaming; one starve cycle, then full.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        alu_valid = 1'b1;
        alu_regno = 6'd3;
        alu_data  = 32'h0000_0303;
        lsu_valid = 1'b1;
        lsu_regno = 6'd20;
        lsu_data  = 32'h0000_2020;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 4) chk("perf_starve", 32'(alu_ready), 32'd0);
            if (c == 6) chk("perf_full", 32'(lsu_ready), 32'd0);
`ifdef WB_PERF_EN
            if (c == 7) chk("perf_stall_cnt", stall_cnt, 32'd3);
`endif
        end

        // Randomized phase with occasional resets and varying load.
        tick();
        for (int c = 0; c < 3000; c++) begin
            int alu_pct;
            alu_pct   = ((c / 500) % 3 == 0) ? 90 : (((c / 500) % 3 == 1) ? 50 : 15);
            rst_n     = ($urandom_range(0, 299) != 0);
            alu_valid = ($urandom_range(0, 99) < alu_pct);
            alu_regno = 6'($urandom);
            alu_data  = $urandom;
            lsu_valid = ($urandom_range(0, 99) < 60);
            lsu_regno = 6'($urandom);
            lsu_data  = $urandom;
            rsv_valid = ($urandom_range(0, 99) < 30);
            rsv_regno = 6'($urandom);
            tick();
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        rsv_valid = 1'b0;
        rst_n     = 1'b1;
        for (int c = 0; c < 10; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and scoreboard that drives the single write port of the CPU register file.
- Merges results from the single-cycle ALU and the load/store unit (LSU), buffering LSU results in a small FIFO.
- Tracks which architectural registers have writes in flight, so issue logic can stall on hazards.
- Sits between the execute/memory stages and the register file's write port (regdata_w/regno_w/write).

## Interface
Parameters:
- LSU_DEPTH, 4: LSU result FIFO entries; power of two, minimum 2.
- STARVE_MAX, 3: consecutive cycles a non-empty LSU FIFO may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted when valid&&ready.
- alu_regno  in  6  destination register; bit 5 ignored.
- alu_data  in  32  result value.
- lsu_valid  in  1  LSU load result valid.
- lsu_ready  out  1  equals !fifo_full; 0 while rst_n=0.
- lsu_regno  in  6  destination register; bit 5 ignored.
- lsu_data  in  32  load value.
- rsv_valid  in  1  issue is reserving a destination register.
- rsv_regno  in  6  register being reserved; bit 5 ignored.
- busy  out  32  bit i=1 when register i has a write pending; bit 0 is always 0.
- regdata_w  out  32  register file write data; registered.
- regno_w  out  6  register file write index; registered; bit 5 always 0.
- write  out  1  register file write enable; registered.

## Operation
- Reset (rst_n=0 at an edge):
  - write=0, regno_w=0, regdata_w=0, busy=0.
  - FIFO emptied, starvation counter=0, alu_ready=0, lsu_ready=0.
  - Reset mid-operation discards all buffered and pending writes.
- LSU path:
  - Accepted beats push into the FIFO. There is no bypass: every LSU beat passes through the FIFO.
  - lsu_ready=!full, with no same-cycle push-on-pop when full.
- Arbitration, evaluated each cycle; exactly one winner or none:
  - starve = fifo_nonempty && wait_cnt==STARVE_MAX.
  - If starve: pop the FIFO head; alu_ready=0.
  - Else if alu_valid: take the ALU; alu_ready=1.
  - Else if fifo_nonempty: pop the head.
  - alu_ready=1 whenever starve=0, including when alu_valid=0.
- wait_cnt:
  - Resets to 0 on any pop or when the FIFO is empty.
  - Otherwise increments (saturating at STARVE_MAX) each cycle the FIFO is non-empty and not popped.
- Winner is registered into regdata_w/regno_w/write on the next edge. No winner gives write=0; regno_w and regdata_w hold their previous values.
- x0 handling:
  - A winner with regno[4:0]==0 is consumed normally (handshake completes) but produces write=0.
  - rsv to x0 is ignored.
- Scoreboard, per-edge update of busy:
  - Clear bit regno_w when write=1.
  - Set bit rsv_regno when rsv_valid=1.
  - Set and clear of the same register on the same edge: set wins (a newer writer is pending).
- Ordering: the block does not reorder writes to the same register. Issue logic must not reserve a register whose busy bit is set.

## Timing
- ALU: accepted at edge E; write=1 during cycle E..E+1. The busy bit clears at edge E+1, the same edge the register file captures the data.
- LSU, empty FIFO, ALU idle: accepted at edge E, popped at E+1, write=1 during E+1..E+2. Latency is 2 cycles.
- Sustained throughput is 1 write per cycle. FIFO count changes by −1, 0, or +1 per edge.
- Worst-case LSU head wait with ALU saturated: STARVE_MAX cycles, then guaranteed service.
- busy reflects a reservation in the cycle after rsv_valid; it is a registered output.
- No combinational path from any *_valid input to any *_ready output. alu_ready depends only on registered state.

## Configuration
- WB_PERF_EN defined:
  - Adds output stall_cnt [31:0], reset to 0.
  - Increments, wrapping at 2^32, each cycle with alu_valid && !alu_ready, plus each cycle with lsu_valid && !lsu_ready (+2 if both).
- WB_PERF_EN undefined: no port, no counter logic; all other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all valids high. Required: write=0, busy=0, both readies 0. After release: lsu_ready=1, alu_ready=1.
- ALU single write: rsv x5, then ALU x5=0xDEADBEEF accepted at edge E. Required: busy[5]=1 before E+1; write=1, regno_w=5, regdata_w=0xDEADBEEF in the cycle after E; busy[5]=0 after E+1.
- LSU starvation: alu_valid held high, one LSU beat x7=0x1234 with default parameters. Required: alu_ready drops for exactly one cycle, 3 cycles after the FIFO head becomes valid; x7 is written then; the ALU resumes the following cycle.
- FIFO full: 5 LSU beats back-to-back with alu_valid high and STARVE_MAX=3. Required: lsu_ready=0 when count=4; no beat is lost; writes appear in push order.
- x0 and collision: ALU write to x0 gives handshake done, write=0. rsv x9 on the same edge a write to x9 retires gives busy[9]=1 afterward.
- With WB_PERF_EN: ALU held off for 1 starve cycle plus LSU full for 2 cycles. Required: stall_cnt=3.
